// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM control unit: the FSM state
// encoding, datapath mux-select codes, ALU operation codes, instruction
// field values and ARM condition codes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_ORR    = 2'b11;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_ADD    = 4'b0100;
  localparam logic [3:0] CMD_SUB    = 4'b0010;
  localparam logic [3:0] CMD_AND    = 4'b0000;
  localparam logic [3:0] CMD_ORR    = 4'b1100;

  localparam logic [3:0] COND_EQ    = 4'b0000;
  localparam logic [3:0] COND_NE    = 4'b0001;
  localparam logic [3:0] COND_CS    = 4'b0010;
  localparam logic [3:0] COND_CC    = 4'b0011;
  localparam logic [3:0] COND_MI    = 4'b0100;
  localparam logic [3:0] COND_PL    = 4'b0101;
  localparam logic [3:0] COND_VS    = 4'b0110;
  localparam logic [3:0] COND_VC    = 4'b0111;
  localparam logic [3:0] COND_HI    = 4'b1000;
  localparam logic [3:0] COND_LS    = 4'b1001;
  localparam logic [3:0] COND_GE    = 4'b1010;
  localparam logic [3:0] COND_LT    = 4'b1011;
  localparam logic [3:0] COND_GT    = 4'b1100;
  localparam logic [3:0] COND_LE    = 4'b1101;
  localparam logic [3:0] COND_AL    = 4'b1110;

endpackage

// File: rtl/arm_mc_condcheck.sv
// Combinational ARM condition evaluation.
//   cond_i    : instruction condition field
//   flags_i   : current {N,Z,C,V}
//   cond_ex_o : 1 when the instruction should execute (1111 never does)
module arm_mc_condcheck
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = flags_i;
    cond_ex_o    = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Control unit for the multicycle ARM core: Moore main FSM, instruction
// decoder, NZCV flag register and condition-gated write enables.
//   clk, reset (async, active-low)
//   Cond/Op/Funct/Rd : instruction register fields
//   ALUFlags         : datapath ALU {N,Z,C,V} for the current cycle
//   outputs          : datapath enables and mux selects
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;
  logic       cond_ex;

  logic next_pc, branch, reg_w, mem_w, ir_w, alu_op;
  logic [3:0] cmd;
  logic       cmd_ok;
  logic [1:0] flag_w;
  logic       reg_w_eff, pcs;

  arm_mc_condcheck u_condcheck (
    .cond_i    (Cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      flags_q   <= '0;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECUTER: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Decoder
  assign cmd    = Funct[4:1];
  assign cmd_ok = (cmd == CMD_ADD) | (cmd == CMD_SUB) |
                  (cmd == CMD_AND) | (cmd == CMD_ORR);

  always_comb begin
    ALUControl = ALU_ADD;
    if (alu_op) begin
      case (cmd)
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
    end
  end

  assign flag_w[1] = alu_op & Funct[0] & cmd_ok;
  assign flag_w[0] = flag_w[1] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));

  assign RegSrc = {Op == OP_MEM, Op == OP_BR};
  assign ImmSrc = Op;

  // ALUWB is only reached from a DP instruction, so an unsupported cmd
  // there means the writeback must be dropped.
  assign reg_w_eff = reg_w & ~((state_q == S_ALUWB) & ~cmd_ok);
  assign pcs       = (reg_w_eff & (Rd == 4'd15)) | branch;

  // Enables are forced low while reset is held, even though FETCH is active.
  assign PCWrite  = reset & (next_pc | (pcs & cond_ok_q));
  assign RegWrite = reset & reg_w_eff & cond_ok_q & (Rd != 4'd15);
  assign MemWrite = reset & mem_w & cond_ok_q;
  assign IRWrite  = reset & ir_w;

  always_comb begin
    cond_ok_d = cond_ok_q;
    if (state_q == S_DECODE) cond_ok_d = cond_ex;
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & cond_ok_q) flags_d[3:2] = ALUFlags[3:2];
    if (flag_w[0] & cond_ok_q) flags_d[1:0] = ALUFlags[1:0];
  end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Control unit for the multicycle ARM core; sits directly upstream of the datapath and drives every datapath select and enable each cycle.
- Decodes the instruction-register fields and sequences each instruction through a Moore main FSM.
- Evaluates ARM condition codes against an internal NZCV flag register.
- Gates PC, register-file and memory writes on that condition result.

Parameters:
- none (ISA subset fixed: DP ADD/SUB/AND/ORR reg/imm, LDR/STR imm offset, B)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S/L)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  datapath ALU flags {N,Z,C,V}, valid in the current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0=PC, 1=Result as memory address
- RegSrc  out  2  [0]=1 reads R15 as RA1; [1]=1 reads Rd as RA2
- ALUSrcA  out  2  00=A (RD1), 01=PC, 10/11 reserved (drive 00)
- ALUSrcB  out  2  00=WriteData (RD2), 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  equals Op
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

Behaviour:
- Reset (async, reset=0): state←FETCH, Flags←0000, cond_ok←0.
  - While reset is low, PCWrite/MemWrite/RegWrite/IRWrite are forced 0.
  - While reset is low, mux selects take FETCH values.
  - Reset mid-instruction aborts immediately; FETCH resumes on the first edge after release.
- FSM states (Moore outputs; unlisted outputs 0/00; ALUOp is internal):
  - FETCH: AdrSrc0, ALUSrcA01, ALUSrcB10, ResultSrc10, IRWrite, NextPC, ALUOp0. → DECODE.
  - DECODE: ALUSrcA01, ALUSrcB10, ResultSrc10, ALUOp0; captures cond_ok. Next state by Op:
    - Op=01 → MEMADR
    - Op=00, Funct[5]=0 → EXECUTER; Funct[5]=1 → EXECUTEI
    - Op=10 → BRANCH
    - Op=11 → FETCH (instruction dropped, no writes)
  - MEMADR: ALUSrcA00, ALUSrcB01, ALUOp0. Funct[0]=1 → MEMRD; else → MEMWR.
  - MEMRD: ResultSrc00, AdrSrc1. → MEMWB.
  - MEMWB: ResultSrc01, RegW. → FETCH.
  - MEMWR: ResultSrc00, AdrSrc1, MemW. → FETCH.
  - EXECUTER: ALUSrcA00, ALUSrcB00, ALUOp1. → ALUWB.
  - EXECUTEI: ALUSrcA00, ALUSrcB01, ALUOp1. → ALUWB.
  - ALUWB: ResultSrc00, RegW. → FETCH.
  - BRANCH: ALUSrcA00, ALUSrcB01, ResultSrc10, ALUOp0, Branch. → FETCH.
  - Illegal encodings → FETCH.
- Instruction latencies: B 3 cycles, STR 4, DP 4, LDR 5.
- Decode (combinational):
  - RegSrc[0] = (Op==10); RegSrc[1] = (Op==01); ImmSrc = Op.
  - ALUControl: ALUOp=0 → 00; otherwise by Funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11.
  - Unsupported cmd → ALUControl 00, with RegW and FlagW suppressed.
  - FlagW[1] = ALUOp & Funct[0] (NZ); FlagW[0] = ALUOp & Funct[0] & cmd∈{ADD,SUB} (CV).
- Condition logic:
  - CondEx is a pure function of Cond and Flags for all 15 ARM codes; 1110=AL always true; 1111 is treated false.
  - cond_ok is registered at the end of DECODE and held until the next DECODE.
  - Flags[3:2] ← ALUFlags[3:2] at the end of an EXECUTE* cycle when FlagW[1] & cond_ok.
  - Flags[1:0] ← ALUFlags[1:0] under the same rule with FlagW[0].
  - A flag write and the condition read never coincide: cond_ok always uses pre-instruction flags.
- Write gating:
  - PCS = (RegW & Rd==15) | Branch.
  - PCWrite = NextPC | (PCS & cond_ok).
  - RegWrite = RegW & cond_ok & (Rd≠15).
  - MemWrite = MemW & cond_ok.
- A failed condition still walks the full state sequence (fixed latency) with all gated writes suppressed.

Decomposition:
- Shared package arm_mc_pkg:
  - State enum (4-bit encoding).
  - Mux-select constants: SRCA_*, SRCB_*, RES_*.
  - ALU op codes ALU_ADD/SUB/AND/ORR.
  - Op-field constants OP_DP/OP_MEM/OP_BR.
  - Condition-code constants.
- Sub-module arm_mc_condcheck: combinational Cond × NZCV → CondEx, reused by both the flag-update and write-gating paths.
- FSM, decoder and flag registers live in arm_mc_controller.

Test Plan:
- Hold reset=0 for 3 cycles, then release → all enables 0 during reset; first cycle after release is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- ADD R1,R2,R3 (0xE0821003) → states FETCH,DECODE,EXECUTER,ALUWB; ALUWB asserts RegWrite=1, ALUControl=00; Flags unchanged.
- LDR R1,[R2,#4] (0xE5921004) → 5 cycles; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1. STR (0xE5821004) → 4 cycles, MemWrite=1 only in MEMWR.
- SUBS R0,R0,R0 (0xE0500000) with ALUFlags=0110 → Flags=0110; then BEQ (0x0A000002) → BRANCH PCWrite=1; repeat with ALUFlags=0000 → BEQ PCWrite=0, 3 cycles.
- ADD PC,R2,R3 (0xE082F003) → ALUWB PCWrite=1, RegWrite=0; Op=11 word (0xEC000000) → FETCH,DECODE,FETCH with no writes.
- Assert reset=0 asynchronously mid-MEMWR → MemWrite drops within the same cycle; after release, FSM restarts in FETCH and Flags=0000.
